// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants, tick derivations and FSM state type for servo_ctrl
package servo_pkg;

  localparam int unsigned ANGLE_MAX = 180;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_RAMP
  } state_t;

  function automatic logic [31:0] calc_period(input int unsigned clk_freq, input int unsigned pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

  // Pulse width in clk ticks for a duration given in microseconds.
  function automatic logic [31:0] calc_ticks(input int unsigned clk_freq, input int unsigned us);
    return (clk_freq / 1_000_000) * us;
  endfunction

  function automatic logic [31:0] calc_center(input logic [31:0] min_t, input logic [31:0] max_t);
    return (min_t + max_t) / 2;
  endfunction

endpackage

// File: rtl/servo_div.sv
// rtl/servo_div.sv - 32-bit unsigned restoring divider, one quotient bit per cycle
module servo_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d, done_q, done_d;
  logic [63:0] step;

  function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                           input logic [31:0] d);
    logic [32:0] trial;
    logic [32:0] diff;
    trial = {rem, quo[31]};
    diff  = trial - {1'b0, d};
    if (trial >= {1'b0, d}) return {diff[31:0], quo[30:0], 1'b1};
    return {trial[31:0], quo[30:0], 1'b0};
  endfunction

  // The first iteration runs on the start edge, so done lands 32 cycles after start.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    step   = div_step(start ? 32'd0 : rem_q, start ? dividend : quo_q, start ? divisor : div_q);
    if (start) begin
      rem_d = step[63:32];
      quo_d = step[31:0];
      div_d = divisor;
      cnt_d = 5'd31;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = step[63:32];
      quo_d = step[31:0];
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/servo_ctrl.sv
// rtl/servo_ctrl.sv - angle command to PWM duty converter with per-frame bounded ramping
module servo_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned PWM_FREQ     = 50,
  parameter int unsigned MIN_PULSE_US = 1000,
  parameter int unsigned MAX_PULSE_US = 2000,
  parameter int unsigned STEP_TICKS   = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_angle,
  output logic        cmd_ready,
  input  logic        enable,
  output logic [31:0] duty_cycle,
  output logic [31:0] period,
  output logic        busy,
  output logic        cmd_error
);

  localparam logic [31:0] PERIOD_T = calc_period(CLK_FREQ, PWM_FREQ);
  localparam logic [31:0] MIN_T    = calc_ticks(CLK_FREQ, MIN_PULSE_US);
  localparam logic [31:0] MAX_T    = calc_ticks(CLK_FREQ, MAX_PULSE_US);
  localparam logic [31:0] CENTER   = calc_center(MIN_T, MAX_T);
  localparam logic [31:0] STEP     = STEP_TICKS;

  state_t      state_q, state_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] target_q, target_d, current_q, current_d, duty_q, duty_d;
  logic        cmd_error_q, cmd_error_d;
  logic        frame_tick, accept, angle_bad, div_start, div_done, reached;
  logic [31:0] dividend, div_quo, gap, step_val;

  servo_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (ANGLE_MAX),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    frame_tick  = (frame_cnt_q == PERIOD_T - 32'd1);
    frame_cnt_d = frame_tick ? 32'd0 : frame_cnt_q + 32'd1;
    accept      = cmd_valid && cmd_ready;
    angle_bad   = {24'd0, cmd_angle} > ANGLE_MAX;
    div_start   = accept && !angle_bad;
    dividend    = {24'd0, cmd_angle} * (MAX_T - MIN_T);
    cmd_error_d = accept && angle_bad;

    gap      = (target_q >= current_q) ? target_q - current_q : current_q - target_q;
    reached  = (gap <= STEP);
    step_val = reached ? target_q :
               (target_q > current_q) ? current_q + STEP : current_q - STEP;

    state_d   = state_q;
    target_d  = target_q;
    current_d = current_q;
    if (state_q == ST_RAMP && frame_tick) current_d = step_val;
    case (state_q)
      ST_CALC: begin
        // A frame_tick coinciding with completion does not step; the next one will.
        if (div_done) begin
          target_d = MIN_T + div_quo;
          state_d  = (MIN_T + div_quo == current_q) ? ST_IDLE : ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (div_start)                 state_d = ST_CALC;
        else if (frame_tick && reached) state_d = ST_IDLE;
      end
      default: begin
        if (div_start) state_d = ST_CALC;
      end
    endcase

    duty_d = enable ? current_q : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      target_q    <= CENTER;
      current_q   <= CENTER;
      duty_q      <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      target_q    <= target_d;
      current_q   <= current_d;
      duty_q      <= duty_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign cmd_ready  = (state_q != ST_CALC);
  assign busy       = (state_q != ST_IDLE);
  assign cmd_error  = cmd_error_q;
  assign duty_cycle = duty_q;
  assign period     = PERIOD_T;

endmodule

// File: tb/tb_servo_ctrl.sv
// tb/tb_servo_ctrl.sv - scoreboard bench for servo_ctrl (short frame keeps the run brief)
module tb_servo_ctrl;

  localparam int PERIOD = 2500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_angle = 8'd0;
  logic        enable = 1'b1;
  logic        cmd_ready, busy, cmd_error;
  logic [31:0] duty_cycle, period;

  servo_ctrl #(
    .CLK_FREQ     (1_000_000),
    .PWM_FREQ     (400),
    .MIN_PULSE_US (1000),
    .MAX_PULSE_US (2000),
    .STEP_TICKS   (250)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_angle  (cmd_angle),
    .cmd_ready  (cmd_ready),
    .enable     (enable),
    .duty_cycle (duty_cycle),
    .period     (period),
    .busy       (busy),
    .cmd_error  (cmd_error)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_duty = 32'd0;
  bit          mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Every duty_cycle change must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && duty_cycle !== prev_duty) begin
      if (exp_q.size() == 0) check("duty_unexpected", duty_cycle, prev_duty);
      else                   check("duty", duty_cycle, exp_q.pop_front());
      prev_duty = duty_cycle;
    end
  end

  task automatic reset_checks();
    check("rst_duty", duty_cycle, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_error", {31'd0, cmd_error}, 32'd0);
    check("rst_period", period, PERIOD);
  endtask

  task automatic do_reset();
    @(negedge clk);
    if (duty_cycle != 32'd0) exp_q.push_back(32'd0);
    rst_n = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    if (enable) exp_q.push_back(32'd1500);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] a);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_angle = a;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic calc_len(input string tag);
    int n;
    n = 0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!cmd_ready && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, "_calc_cycles"}, n, 32);
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    reset_checks();
    mon_en = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'd1500);
    rst_n = 1'b1;
    drain("reset", 10);

    // Full-scale angle: two bounded steps to 2000.
    exp_q.push_back(32'd1750);
    exp_q.push_back(32'd2000);
    send(8'd180);
    check("a180_ready_low", {31'd0, cmd_ready}, 32'd0);
    calc_len("a180");
    drain("a180", 3 * PERIOD);
    check("a180_idle", {31'd0, busy}, 32'd0);

    // Angle 100 from center floors to 1555, reached in a single step.
    do_reset();
    drain("reset2", 10);
    exp_q.push_back(32'd1555);
    send(8'd100);
    calc_len("a100");
    drain("a100", 2 * PERIOD);
    check("a100_idle", {31'd0, busy}, 32'd0);

    // Out-of-range angle: error pulse only.
    send(8'd200);
    check("a200_error", {31'd0, cmd_error}, 32'd1);
    check("a200_ready", {31'd0, cmd_ready}, 32'd1);
    check("a200_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("a200_error_clr", {31'd0, cmd_error}, 32'd0);
    repeat (PERIOD + 10) @(posedge clk);
    check("a200_no_change", exp_q.size(), 0);
    check("a200_still_idle", {31'd0, busy}, 32'd0);

    // Retarget to 0 while ramping at 1750.
    do_reset();
    drain("reset3", 10);
    exp_q.push_back(32'd1750);
    send(8'd180);
    drain("retarget_up", 2 * PERIOD);
    exp_q.push_back(32'd1500);
    exp_q.push_back(32'd1250);
    exp_q.push_back(32'd1000);
    send(8'd0);
    calc_len("a0");
    drain("a0", 4 * PERIOD);
    check("a0_idle", {31'd0, busy}, 32'd0);

    // Disable mid-ramp, re-enable after three frames.
    do_reset();
    drain("reset4", 10);
    exp_q.push_back(32'd1750);
    send(8'd180);
    drain("en_up", 2 * PERIOD);
    @(negedge clk);
    exp_q.push_back(32'd0);
    enable = 1'b0;
    drain("en_off", 5);
    repeat (3 * PERIOD) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(32'd2000);
    enable = 1'b1;
    drain("en_on", 5);
    check("en_idle", {31'd0, busy}, 32'd0);

    // Reset during CALC: target must return to center, so no ramp follows.
    send(8'd0);
    check("rcalc_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(posedge clk);
    do_reset();
    drain("rcalc", 10);
    repeat (2 * PERIOD) @(posedge clk);
    @(negedge clk);
    check("rcalc_no_ramp", exp_q.size(), 0);
    check("rcalc_idle", {31'd0, busy}, 32'd0);
    check("rcalc_duty", duty_cycle, 32'd1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
